// File: rtl/ps2_voice_scheduler_pkg.sv
// Shared constants for the PS/2 voice scheduler: prefix bytes, key map,
// parser state encoding and voice-index width.
package ps2_voice_pkg;

  localparam int unsigned NUM_VOICE_KEYS = 4;
  localparam int unsigned VOICE_W        = 2;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Entry i is the make code that triggers voice i.
  localparam logic [NUM_VOICE_KEYS-1:0][7:0] KEY_MAP = {8'h2B, 8'h23, 8'h1B, 8'h1C};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } parser_state_e;

  typedef struct packed {
    logic               hit;
    logic [VOICE_W-1:0] idx;
  } key_lookup_t;

  function automatic key_lookup_t key_lookup(input logic [7:0] code);
    key_lookup_t r;
    r = '0;
    for (int unsigned i = 0; i < NUM_VOICE_KEYS; i++) begin
      if (code == KEY_MAP[i]) begin
        r.hit = 1'b1;
        r.idx = VOICE_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_voice_scheduler_rr_arbiter4.sv
// Combinational 4-way round-robin pick: first set pending bit at or above
// rr_ptr, wrapping 3 -> 0.
module rr_arbiter4
  import ps2_voice_pkg::*;
(
  input  logic [3:0]         pending,
  input  logic [VOICE_W-1:0] rr_ptr,
  output logic               grant_valid,
  output logic [VOICE_W-1:0] grant_idx
);

  always_comb begin
    logic [VOICE_W-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = rr_ptr + VOICE_W'(k);
      if (!grant_valid && pending[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ps2_voice_scheduler.sv
// PS/2 scan-code parser and round-robin trigger scheduler for the 808 kit.
// Optional prefix timeout enabled by defining PS2_PREFIX_TIMEOUT_EN.
module ps2_voice_scheduler
  import ps2_voice_pkg::*;
#(
  parameter int unsigned NUM_VOICES  = 4,
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [7:0]            ps2_data,
  input  logic                  ps2_data_en,
  output logic                  play_req,
  output logic [VOICE_W-1:0]    play_voice,
  input  logic                  play_ack,
  output logic [NUM_VOICES-1:0] key_held,
  output logic [7:0]            last_code
);

  parser_state_e             state_q, state_d;
  logic [NUM_VOICES-1:0]     key_held_q, key_held_d;
  logic [NUM_VOICES-1:0]     pending_q, pending_d;
  logic [VOICE_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [VOICE_W-1:0]        play_voice_q, play_voice_d;
  logic                      play_req_q, play_req_d;
  logic [7:0]                last_code_q;

  key_lookup_t               lk;
  logic                      make_ev, brk_ev;
  logic                      grant_valid;
  logic [VOICE_W-1:0]        grant_idx;
  logic [NUM_VOICES-1:0]     ev_onehot, set_vec, clr_vec;
  logic                      ack_fire;

  assign lk = key_lookup(ps2_data);

`ifdef PS2_PREFIX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_expire;

  always_comb begin
    to_cnt_d  = to_cnt_q + TO_W'(1);
    to_expire = 1'b0;
    if (ps2_data_en || state_q == ST_IDLE) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
      to_expire = 1'b1;
      to_cnt_d  = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  logic to_expire;
  assign to_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    make_ev = 1'b0;
    brk_ev  = 1'b0;
    if (ps2_data_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (ps2_data == PS2_BREAK)    state_d = ST_BRK;
          else if (ps2_data == PS2_EXT) state_d = ST_EXT;
          else if (lk.hit)              make_ev = 1'b1;
        end
        ST_BRK: begin
          if (ps2_data == PS2_BREAK)    state_d = ST_BRK;
          else if (ps2_data == PS2_EXT) state_d = ST_EXT;
          else begin
            brk_ev  = lk.hit;
            state_d = ST_IDLE;
          end
        end
        ST_EXT:     state_d = (ps2_data == PS2_BREAK) ? ST_EXT_BRK : ST_IDLE;
        ST_EXT_BRK: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end else if (to_expire) begin
      state_d = ST_IDLE;
    end
  end

  rr_arbiter4 u_arb (
    .pending     (pending_q[3:0]),
    .rr_ptr      (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign ev_onehot = NUM_VOICES'(1) << lk.idx;
  assign ack_fire  = play_req_q && play_ack;
  // Auto-repeat makes on an already-held key must not re-trigger.
  assign set_vec   = (make_ev && !key_held_q[lk.idx]) ? ev_onehot : '0;
  assign clr_vec   = ack_fire ? (NUM_VOICES'(1) << play_voice_q) : '0;

  always_comb begin
    key_held_d = key_held_q;
    if (make_ev) key_held_d = key_held_q | ev_onehot;
    if (brk_ev)  key_held_d = key_held_q & ~ev_onehot;
    // Set is OR-ed after the clear so a same-cycle retrigger survives.
    pending_d    = (pending_q & ~clr_vec) | set_vec;
    play_req_d   = play_req_q;
    play_voice_d = play_voice_q;
    rr_ptr_d     = rr_ptr_q;
    if (ack_fire) begin
      play_req_d = 1'b0;
      rr_ptr_d   = play_voice_q + VOICE_W'(1);
    end else if (!play_req_q && grant_valid) begin
      play_req_d   = 1'b1;
      play_voice_d = grant_idx;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      key_held_q   <= '0;
      pending_q    <= '0;
      rr_ptr_q     <= '0;
      play_req_q   <= 1'b0;
      play_voice_q <= '0;
      last_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      key_held_q   <= key_held_d;
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      play_req_q   <= play_req_d;
      play_voice_q <= play_voice_d;
      if (ps2_data_en) last_code_q <= ps2_data;
    end
  end

  assign play_req   = play_req_q;
  assign play_voice = play_voice_q;
  assign key_held   = key_held_q;
  assign last_code  = last_code_q;

endmodule

// File: tb/tb_ps2_voice_scheduler.sv
// Directed self-checking bench for ps2_voice_scheduler.
module tb_ps2_voice_scheduler;

  localparam int unsigned TB_TIMEOUT = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ps2_data = '0;
  logic       ps2_data_en = 1'b0;
  logic       play_req;
  logic [1:0] play_voice;
  logic       play_ack = 1'b0;
  logic [3:0] key_held;
  logic [7:0] last_code;

  int total = 0;
  int bad   = 0;
  int req_cnt = 0;
  logic req_prev = 1'b0;

  ps2_voice_scheduler #(.NUM_VOICES(4), .TIMEOUT_CYC(TB_TIMEOUT)) dut (
    .CLOCK_50    (clk),
    .reset       (rst),
    .ps2_data    (ps2_data),
    .ps2_data_en (ps2_data_en),
    .play_req    (play_req),
    .play_voice  (play_voice),
    .play_ack    (play_ack),
    .key_held    (key_held),
    .last_code   (last_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (play_req && !req_prev) req_cnt = req_cnt + 1;
    req_prev = play_req;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    ps2_data    = b;
    ps2_data_en = 1'b1;
    @(negedge clk);
    ps2_data_en = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (play_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic ack_voice(input string name, input logic [1:0] exp_v, input int dly);
    bit ok;
    wait_req(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_req_timeout: play_req=%b required 1", name, play_req);
    end else begin
      total++;
      if (play_voice !== exp_v) begin
        bad++;
        $display("FAIL %s_voice: play_voice=%0d required %0d", name, play_voice, exp_v);
      end
      for (int i = 1; i < dly; i++) @(negedge clk);
      total++;
      if (play_voice !== exp_v || play_req !== 1'b1) begin
        bad++;
        $display("FAIL %s_hold: req=%b voice=%0d required 1/%0d", name, play_req, play_voice, exp_v);
      end
      play_ack = 1'b1;
      @(negedge clk);
      play_ack = 1'b0;
      total++;
      if (play_req !== 1'b0) begin
        bad++;
        $display("FAIL %s_drop: play_req=%b required 0", name, play_req);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({play_req, play_voice, key_held, last_code} !== 15'd0) begin
      bad++;
      $display("FAIL reset_outputs: got req=%b v=%0d held=%b last=%h required all 0",
               play_req, play_voice, key_held, last_code);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tap();
    int base;
    base = req_cnt;
    send_byte(8'h1C);
    total++;
    if (key_held !== 4'b0001 || play_req !== 1'b0) begin
      bad++;
      $display("FAIL tap_k: held=%b req=%b required 0001/0", key_held, play_req);
    end
    @(negedge clk);
    total++;
    if (play_req !== 1'b1 || play_voice !== 2'd0) begin
      bad++;
      $display("FAIL tap_k1: req=%b voice=%0d required 1/0", play_req, play_voice);
    end
    ack_voice("tap", 2'd0, 3);
    send_byte(8'hF0);
    send_byte(8'h1C);
    total++;
    if (key_held !== 4'b0000) begin
      bad++;
      $display("FAIL tap_release: held=%b required 0000", key_held);
    end
    repeat (8) @(negedge clk);
    total++;
    if (req_cnt - base !== 1) begin
      bad++;
      $display("FAIL tap_count: requests=%0d required 1", req_cnt - base);
    end
  endtask

  task automatic test_autorepeat();
    int base;
    base = req_cnt;
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    ack_voice("rep", 2'd0, 2);
    send_byte(8'hF0);
    send_byte(8'h1C);
    repeat (8) @(negedge clk);
    total++;
    if (req_cnt - base !== 1 || key_held !== 4'b0000) begin
      bad++;
      $display("FAIL rep_count: requests=%0d held=%b required 1/0000", req_cnt - base, key_held);
    end
  endtask

  task automatic test_round_robin();
    send_byte(8'h1B);
    send_byte(8'h23);
    send_byte(8'h2B);
    total++;
    if (key_held !== 4'b1110) begin
      bad++;
      $display("FAIL rr_held: held=%b required 1110", key_held);
    end
    ack_voice("rr_v1", 2'd1, 1);
    ack_voice("rr_v2", 2'd2, 1);
    ack_voice("rr_v3", 2'd3, 1);
    total++;
    if (dut.rr_ptr_q !== 2'd0) begin
      bad++;
      $display("FAIL rr_ptr: rr_ptr=%0d required 0", dut.rr_ptr_q);
    end
    send_byte(8'hF0); send_byte(8'h1B);
    send_byte(8'hF0); send_byte(8'h23);
    send_byte(8'hF0); send_byte(8'h2B);
    total++;
    if (key_held !== 4'b0000) begin
      bad++;
      $display("FAIL rr_release: held=%b required 0000", key_held);
    end
  endtask

  task automatic test_extended();
    int base;
    base = req_cnt;
    send_byte(8'hE0); send_byte(8'h1C);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h1C);
    repeat (6) @(negedge clk);
    total++;
    if (req_cnt - base !== 0 || key_held !== 4'b0000 || last_code !== 8'h1C) begin
      bad++;
      $display("FAIL ext_ignore: requests=%0d held=%b last=%h required 0/0000/1c",
               req_cnt - base, key_held, last_code);
    end
  endtask

  task automatic test_stray_ack();
    int base;
    base = req_cnt;
    @(negedge clk);
    play_ack = 1'b1;
    @(negedge clk);
    play_ack = 1'b0;
    send_byte(8'h23);
    ack_voice("stray", 2'd2, 1);
    send_byte(8'hF0); send_byte(8'h23);
    repeat (6) @(negedge clk);
    total++;
    if (req_cnt - base !== 1) begin
      bad++;
      $display("FAIL stray_count: requests=%0d required 1", req_cnt - base);
    end
  endtask

  task automatic test_set_clear();
    bit ok;
    int base;
    base = req_cnt;
    send_byte(8'h1C);
    wait_req(ok);
    send_byte(8'hF0);
    send_byte(8'h1C);
    @(negedge clk);
    ps2_data    = 8'h1C;
    ps2_data_en = 1'b1;
    play_ack    = 1'b1;
    @(negedge clk);
    ps2_data_en = 1'b0;
    play_ack    = 1'b0;
    total++;
    if (play_req !== 1'b0 || key_held !== 4'b0001) begin
      bad++;
      $display("FAIL sc_edge: req=%b held=%b required 0/0001", play_req, key_held);
    end
    ack_voice("sc_retrig", 2'd0, 1);
    send_byte(8'hF0); send_byte(8'h1C);
    repeat (6) @(negedge clk);
    total++;
    if (req_cnt - base !== 2) begin
      bad++;
      $display("FAIL sc_count: requests=%0d required 2", req_cnt - base);
    end
  endtask

  task automatic test_reset_midhandshake();
    bit ok;
    int base;
    send_byte(8'h1B);
    send_byte(8'h23);
    wait_req(ok);
    total++;
    if (!ok || play_voice !== 2'd1 || dut.pending_q !== 4'b0110) begin
      bad++;
      $display("FAIL mid_setup: req=%b voice=%0d pending=%b required 1/1/0110",
               play_req, play_voice, dut.pending_q);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({play_req, play_voice, key_held, last_code} !== 15'd0) begin
      bad++;
      $display("FAIL mid_async: req=%b v=%0d held=%b last=%h required all 0",
               play_req, play_voice, key_held, last_code);
    end
    @(negedge clk);
    rst = 1'b0;
    base = req_cnt;
    repeat (10) @(negedge clk);
    total++;
    if (req_cnt - base !== 0 || play_req !== 1'b0) begin
      bad++;
      $display("FAIL mid_after: requests=%0d required 0", req_cnt - base);
    end
  endtask

  task automatic test_prefix_timeout();
    int base;
    base = req_cnt;
    send_byte(8'hF0);
    repeat (TB_TIMEOUT + 1) @(negedge clk);
    send_byte(8'h1C);
`ifdef PS2_PREFIX_TIMEOUT_EN
    total++;
    if (key_held !== 4'b0001) begin
      bad++;
      $display("FAIL to_make: held=%b required 0001", key_held);
    end
    ack_voice("to", 2'd0, 1);
    send_byte(8'hF0); send_byte(8'h1C);
`else
    repeat (6) @(negedge clk);
    total++;
    if (key_held !== 4'b0000 || req_cnt - base !== 0) begin
      bad++;
      $display("FAIL to_break: held=%b requests=%0d required 0000/0", key_held, req_cnt - base);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_tap();
    test_autorepeat();
    test_round_robin();
    test_extended();
    test_stray_ack();
    test_set_clear();
    test_reset_midhandshake();
    test_prefix_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, required completion");
    $fatal(1);
  end

endmodule
